// File: rtl/score_keeper.sv
// Run/high score keeper for the game: BCD run score, persistent high score,
// and four active-low seven-segment displays that blink after a game over.
module score_keeper #(
  parameter int unsigned FRAMES_PER_POINT = 6,
  parameter int unsigned BLINK_FRAMES     = 30
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        go,
  input  logic        frame_tick,
  input  logic        game_over,
  input  logic        clear_high,
  input  logic        show_high,
  output logic [15:0] score_bcd,
  output logic [15:0] high_bcd,
  output logic        new_high,
  output logic        running,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3
);

  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

  localparam logic [3:0] FRAME_LAST = 4'(FRAMES_PER_POINT - 1);
  localparam logic [5:0] BLINK_LAST = 6'(BLINK_FRAMES - 1);

  state_t      state;
  logic [3:0]  frame_cnt;
  logic [5:0]  blink_cnt;
  logic        blank;
  logic        go_q;
  logic        over_q;
  logic        go_rise;
  logic        over_rise;
  logic        at_point;
  logic [15:0] score_next;
  logic [15:0] shown;

  // Saturating 4-digit BCD increment; 9999 stays put.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v != 16'h9999) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (carry) begin
          if (r[i*4 +: 4] == 4'd9) begin
            r[i*4 +: 4] = 4'd0;
          end else begin
            r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  always_comb begin
    go_rise    = go & ~go_q;
    over_rise  = game_over & ~over_q;
    at_point   = frame_tick && (frame_cnt == FRAME_LAST);
    score_next = at_point ? bcd_inc(score_bcd) : score_bcd;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      score_bcd <= '0;
      high_bcd  <= '0;
      frame_cnt <= '0;
      blink_cnt <= '0;
      blank     <= 1'b0;
      new_high  <= 1'b0;
      running   <= 1'b0;
      go_q      <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      go_q     <= go;
      over_q   <= game_over;
      new_high <= 1'b0;
      case (state)
        IDLE: begin
          if (go_rise) begin
            state     <= RUN;
            running   <= 1'b1;
            score_bcd <= '0;
            frame_cnt <= '0;
          end
        end
        RUN: begin
          if (frame_tick) frame_cnt <= at_point ? '0 : frame_cnt + 4'd1;
          score_bcd <= score_next;
          // Game over takes priority over a simultaneous go edge, and the
          // final score includes any point scored on this very cycle.
          if (over_rise) begin
            state   <= OVER;
            running <= 1'b0;
            if (score_next > high_bcd) begin
              high_bcd <= score_next;
              new_high <= ~clear_high;
            end
          end
        end
        OVER: begin
          if (frame_tick) begin
            if (blink_cnt == BLINK_LAST) begin
              blink_cnt <= '0;
              blank     <= ~blank;
            end else begin
              blink_cnt <= blink_cnt + 6'd1;
            end
          end
          if (go_rise) begin
            state     <= RUN;
            running   <= 1'b1;
            score_bcd <= '0;
            frame_cnt <= '0;
            blink_cnt <= '0;
            blank     <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase
      if (clear_high) high_bcd <= '0;
    end
  end

  always_comb begin
    shown = show_high ? high_bcd : score_bcd;
    if (blank) begin
      HEX0 = 7'h7F;
      HEX1 = 7'h7F;
      HEX2 = 7'h7F;
      HEX3 = 7'h7F;
    end else begin
      HEX0 = seg(shown[3:0]);
      HEX1 = seg(shown[7:4]);
      HEX2 = seg(shown[11:8]);
      HEX3 = seg(shown[15:12]);
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: scoring, carry, saturation, high score,
// blinking and edge/priority corner cases.
module tb_score_keeper;

  logic        clock = 1'b0;
  logic        reset;
  logic        go;
  logic        frame_tick;
  logic        game_over;
  logic        clear_high;
  logic        show_high;
  logic [15:0] score_bcd;
  logic [15:0] high_bcd;
  logic        new_high;
  logic        running;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3;

  int checks = 0;
  int errors = 0;

  score_keeper #(.FRAMES_PER_POINT(6), .BLINK_FRAMES(30)) dut (
    .clock(clock), .reset(reset), .go(go), .frame_tick(frame_tick),
    .game_over(game_over), .clear_high(clear_high), .show_high(show_high),
    .score_bcd(score_bcd), .high_bcd(high_bcd), .new_high(new_high),
    .running(running), .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // frame_tick held high for n consecutive cycles.
  task automatic ticks(input int n);
    frame_tick = 1'b1;
    repeat (n) @(posedge clock);
    #1 frame_tick = 1'b0;
  endtask

  initial begin
    reset = 1'b1; go = 1'b0; frame_tick = 1'b0; game_over = 1'b0;
    clear_high = 1'b0; show_high = 1'b0;
    step(3);
    reset = 1'b0;
    step(1);
    chk("rst_score", score_bcd, 16'h0000);
    chk("rst_high", high_bcd, 16'h0000);
    chk("rst_running", {15'd0, running}, 16'd0);
    chk("rst_new_high", {15'd0, new_high}, 16'd0);
    chk("rst_hex0", {9'd0, HEX0}, 16'h0040);
    chk("rst_hex3", {9'd0, HEX3}, 16'h0040);

    // Start and first point.
    go = 1'b1; step(1); go = 1'b0;
    chk("start_running", {15'd0, running}, 16'd1);
    ticks(6);
    chk("first_score", score_bcd, 16'h0001);
    chk("first_hex0", {9'd0, HEX0}, 16'h0079);
    chk("first_hex1", {9'd0, HEX1}, 16'h0040);
    chk("first_hex2", {9'd0, HEX2}, 16'h0040);
    chk("first_hex3", {9'd0, HEX3}, 16'h0040);

    // Two-digit carry ripple.
    ticks(588);
    chk("score_0099", score_bcd, 16'h0099);
    ticks(6);
    chk("score_0100", score_bcd, 16'h0100);

    // Saturation at 9999 (9899 more points).
    ticks(59394);
    chk("score_9999", score_bcd, 16'h9999);
    ticks(12);
    chk("score_sat", score_bcd, 16'h9999);
    chk("hex3_nine", {9'd0, HEX3}, 16'h0010);

    // Reset mid-game loses everything; new game to 0042.
    reset = 1'b1; step(1); reset = 1'b0;
    chk("midreset_running", {15'd0, running}, 16'd0);
    chk("midreset_score", score_bcd, 16'h0000);
    go = 1'b1; step(1); go = 1'b0;
    ticks(252);
    chk("score_0042", score_bcd, 16'h0042);
    game_over = 1'b1; step(1);
    chk("over1_running", {15'd0, running}, 16'd0);
    chk("over1_high", high_bcd, 16'h0042);
    chk("over1_new_high", {15'd0, new_high}, 16'd1);
    step(1);
    chk("over1_new_high_pulse", {15'd0, new_high}, 16'd0);

    // Blink in OVER.
    ticks(29);
    chk("blink_pre_hex0", {9'd0, HEX0}, 16'h0024);
    ticks(1);
    chk("blink_hex0", {9'd0, HEX0}, 16'h007F);
    chk("blink_hex2", {9'd0, HEX2}, 16'h007F);
    show_high = 1'b1; #1;
    chk("blink_show_high", {9'd0, HEX1}, 16'h007F);
    show_high = 1'b0;
    ticks(30);
    chk("unblink_hex0", {9'd0, HEX0}, 16'h0024);
    chk("unblink_hex1", {9'd0, HEX1}, 16'h0019);

    // Second game to 0017 with go held high throughout.
    game_over = 1'b0; go = 1'b1; step(1);
    chk("game2_running", {15'd0, running}, 16'd1);
    chk("game2_score_clr", score_bcd, 16'h0000);
    ticks(102);
    chk("score_0017", score_bcd, 16'h0017);
    game_over = 1'b1; step(1);
    chk("over2_high", high_bcd, 16'h0042);
    chk("over2_new_high", {15'd0, new_high}, 16'd0);
    chk("over2_hex0_run", {9'd0, HEX0}, 16'h0078);
    show_high = 1'b1; #1;
    chk("over2_hex0_high", {9'd0, HEX0}, 16'h0024);
    show_high = 1'b0;
    step(5);
    chk("held_go_no_restart", {15'd0, running}, 16'd0);
    chk("held_go_score", score_bcd, 16'h0017);
    go = 1'b0; step(1); go = 1'b1; step(1);
    chk("rego_running", {15'd0, running}, 16'd1);
    chk("rego_score", score_bcd, 16'h0000);

    // go and game_over rising together in RUN: game over wins.
    game_over = 1'b0; go = 1'b0; step(1);
    go = 1'b1; game_over = 1'b1; step(1);
    chk("prio_running", {15'd0, running}, 16'd0);
    go = 1'b0; step(1);
    go = 1'b1; step(1);
    chk("prio_restart", {15'd0, running}, 16'd1);

    // go edge in RUN ignored; clear_high beats a new high.
    game_over = 1'b0; go = 1'b0;
    ticks(300);
    chk("score_0050", score_bcd, 16'h0050);
    go = 1'b1; step(1);
    chk("run_go_ignored", score_bcd, 16'h0050);
    game_over = 1'b1; clear_high = 1'b1; step(1);
    clear_high = 1'b0;
    chk("clear_high_val", high_bcd, 16'h0000);
    chk("clear_new_high", {15'd0, new_high}, 16'd0);
    chk("clear_running", {15'd0, running}, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
